trace_capture_buffer: RTL
=========================

Name: trace_capture_buffer

Overview:
- Sink for the tracer's trace stream: captures each record presented with a one-cycle trace_ready strobe, tags it with a cycle timestamp and stores it in a circular buffer.
- Drains to a host or bench through a req/gnt/rvalid read port. This port is the responder side of the same handshake the core uses towards instruction and data memory.
- Sits beside the tracer in system builds and benches, so trace history survives long runs without per-cycle monitoring.

Parameters:
- TRACE_WIDTH, 128, width of one flattened trace record.
- TS_WIDTH, 32, width of the free-running timestamp counter and of the stored tag.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- STOP_ON_FULL, 1, full-buffer policy: 1 = drop the incoming record; 0 = overwrite the oldest entry.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- trace_ready_i  in  1  single-cycle strobe; trace_data_i is valid this cycle.
- trace_data_i  in  TRACE_WIDTH  trace record.
- clear_i  in  1  synchronous flush of buffer contents and status.
- rd_req_i  in  1  read request; held high until granted.
- rd_gnt_o  out  1  read grant; combinational.
- rd_rvalid_o  out  1  read data valid; one cycle after grant.
- rd_rdata_o  out  TS_WIDTH+TRACE_WIDTH  {timestamp, record} of the popped entry.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky; set when any record is dropped or overwritten.
- dropped_o  out  16  saturating count of lost records.

Behaviour:
- Reset: write/read pointers 0, count_o 0, empty_o 1, full_o 0, overflow_o 0, dropped_o 0, rd_gnt_o 0, rd_rvalid_o 0, rd_rdata_o 0, timestamp 0.
  - Reset has priority over every other input.
  - Reset in the cycle after a grant suppresses that rvalid.
- Timestamp:
  - TS_WIDTH counter increments every cycle outside reset and wraps modulo 2^TS_WIDTH.
  - An accepted record is tagged with the counter value of its strobe cycle.
  - clear_i does not reset the timestamp counter.
- Grant: rd_gnt_o = rd_req_i && !empty_o && !clear_i.
  - There is no empty-bypass: a record pushed in the same cycle as a request on an empty buffer is granted the next cycle at the earliest.
  - Back-to-back grants are allowed; throughput is one pop per cycle.
- Response:
  - On a grant cycle, the entry at the read pointer is registered into rd_rdata_o, the read pointer advances and rd_rvalid_o is 1 the next cycle.
  - rd_rdata_o holds its value when rd_rvalid_o is 0.
- Push with not full, or full with a pop granted in the same cycle: write at the write pointer, advance the pointer and update count (+1, or net 0 with a pop). No loss.
- Push when full, no pop, STOP_ON_FULL=1:
  - Record discarded and buffer unchanged.
  - overflow_o is set and dropped_o increments.
- Push when full, no pop, STOP_ON_FULL=0:
  - Record written over the oldest entry; both pointers advance and count stays DEPTH.
  - overflow_o is set and dropped_o increments.
- dropped_o saturates at 16'hFFFF.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count.
- clear_i:
  - Pointers and count go to 0; overflow_o and dropped_o go to 0.
  - A push in the same cycle is ignored and not counted as dropped.
  - An rvalid already due from the previous cycle's grant is still delivered with its data.
- Simultaneous push and pop on a buffer with count 1: the popped entry is the old one; count stays 1.
- X on trace_data_i is stored as-is.
- trace_ready_i must be a single-cycle strobe. If it is held high, each high cycle is a separate push.

Test Plan:
- Reset then push 3 records (A,B,C) on cycles 10,11,12 -> count_o=3; three granted reads return {10,A},{11,B},{12,C} with rvalid one cycle after each grant; empty_o=1 afterwards.
- STOP_ON_FULL=1, DEPTH=16: push 18 records, no reads -> full_o=1, overflow_o=1, dropped_o=2; the drain returns the first 16 records in order.
- STOP_ON_FULL=0, DEPTH=16: push 18 records R0..R17 -> count_o=16, dropped_o=2; the drain returns R2..R17.
- Full buffer, push and rd_req in the same cycle -> grant=1, no drop, count_o stays 16, dropped_o unchanged; the pushed record appears last in the drain.
- Empty buffer, rd_req held high with push on cycle N -> rd_gnt_o=0 at N, 1 at N+1, rvalid at N+2 with that record.
- Grant on cycle N with clear_i at N+1 -> rvalid at N+1 with the granted data; count_o=0 and overflow_o=0 at N+2; no grant in the clear cycle.

Source files
------------

// File: rtl/trace_capture_buffer_if.sv
// Trace-stream and read-port signals of the trace capture buffer.
// The master side is the tracer/host; the slave side is the buffer.
interface trace_capture_buffer_if #(
   parameter int TRACE_WIDTH = 128,
   parameter int TS_WIDTH    = 32
);
   logic                            trace_ready_i;
   logic [TRACE_WIDTH-1:0]          trace_data_i;
   logic                            rd_req_i;
   logic                            rd_gnt_o;
   logic                            rd_rvalid_o;
   logic [TS_WIDTH+TRACE_WIDTH-1:0] rd_rdata_o;

   modport master (
      output trace_ready_i, trace_data_i, rd_req_i,
      input  rd_gnt_o, rd_rvalid_o, rd_rdata_o
   );

   modport slave (
      input  trace_ready_i, trace_data_i, rd_req_i,
      output rd_gnt_o, rd_rvalid_o, rd_rdata_o
   );
endinterface

// File: rtl/trace_capture_buffer.sv
// Circular buffer that timestamps trace records and drains them through
// a req/gnt/rvalid read port, with drop-or-overwrite policy when full.
module trace_capture_buffer #(
   parameter int TRACE_WIDTH  = 128,
   parameter int TS_WIDTH     = 32,
   parameter int DEPTH        = 16,
   parameter int STOP_ON_FULL = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   trace_capture_buffer_if.slave    bus,
   input  logic                     clear_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     overflow_o,
   output logic [15:0]              dropped_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = TS_WIDTH + TRACE_WIDTH;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]         count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [15:0]         dropped_q, dropped_d;
   logic                rvalid_q, rvalid_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic [DW-1:0]       mem_q [DEPTH];

   logic          empty_s, full_s, gnt_s, push_s, loss_s, wr_en_s;
   logic [DW-1:0] wr_data_s;

   // Occupancy flags and handshake qualifiers.
   always_comb begin
      empty_s = (count_q == {(AW+1){1'b0}});
      full_s  = (count_q == DEPTH_C);
      gnt_s   = !rst_i && bus.rd_req_i && !empty_s && !clear_i;
      push_s  = bus.trace_ready_i && !clear_i;
   end

   // Next-state for pointers, occupancy, read response and loss status.
   always_comb begin
      ts_d       = ts_q + TS_WIDTH'(1'b1);
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      rdata_d    = rdata_q;
      rvalid_d   = gnt_s;
      loss_s     = 1'b0;
      wr_en_s    = 1'b0;
      wr_data_s  = {ts_q, bus.trace_data_i};
      if (clear_i) begin
         wptr_d     = {AW{1'b0}};
         rptr_d     = {AW{1'b0}};
         count_d    = {(AW+1){1'b0}};
         overflow_d = 1'b0;
         dropped_d  = 16'd0;
      end else begin
         if (gnt_s) begin
            rdata_d = mem_q[rptr_q];
            rptr_d  = rptr_q + PTR_ONE;
         end else begin
            rdata_d = rdata_q;
         end
         if (push_s) begin
            if (!full_s || gnt_s) begin
               wr_en_s = 1'b1;
               wptr_d  = wptr_q + PTR_ONE;
               count_d = gnt_s ? count_q : count_q + CNT_ONE;
            end else if (STOP_ON_FULL != 0) begin
               loss_s = 1'b1;
            end else begin
               // Overwrite the oldest entry: the read side skips past it.
               wr_en_s = 1'b1;
               wptr_d  = wptr_q + PTR_ONE;
               rptr_d  = rptr_q + PTR_ONE;
               loss_s  = 1'b1;
            end
         end else if (gnt_s) begin
            count_d = count_q - CNT_ONE;
         end else begin
            count_d = count_q;
         end
         if (loss_s) begin
            overflow_d = 1'b1;
            dropped_d  = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
         end else begin
            overflow_d = overflow_q;
         end
      end
   end

   // Control and status registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_q       <= {TS_WIDTH{1'b0}};
         wptr_q     <= {AW{1'b0}};
         rptr_q     <= {AW{1'b0}};
         count_q    <= {(AW+1){1'b0}};
         overflow_q <= 1'b0;
         dropped_q  <= 16'd0;
         rvalid_q   <= 1'b0;
         rdata_q    <= {DW{1'b0}};
      end else begin
         ts_q       <= ts_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   // Entry storage; contents need no reset since occupancy guards reads.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[wptr_q] <= wr_data_s;
      end
   end

   assign bus.rd_gnt_o    = gnt_s;
   assign bus.rd_rvalid_o = rvalid_q && !rst_i;
   assign bus.rd_rdata_o  = rdata_q;
   assign count_o         = count_q;
   assign empty_o         = empty_s;
   assign full_o          = full_s;
   assign overflow_o      = overflow_q;
   assign dropped_o       = dropped_q;
endmodule
